alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_pkg.sv | 24 ++
 rtl/regfile_4x16.sv | 31 +++
 rtl/alu_ctrl.sv | 114 +++++++++++
 tb/tb_alu_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU controller: data width, op codes and FSM state encoding.
package alu_pkg;
  localparam int DATA_W = 16;
  localparam int NREG   = 4;

  typedef enum logic [2:0] {
    OP_SHL = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_XOR = 3'd3,
    OP_OR  = 3'd4,
    OP_AND = 3'd5,
    OP_SHR = 3'd6,
    OP_NOT = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE_B = 3'd1,
    EXEC    = 3'd2,
    READ    = 3'd3,
    DONE    = 3'd4
  } state_e;
endpackage

// File: rtl/regfile_4x16.sv
// Four 16-bit registers: one synchronous write port, operand A/B and host combinational reads.
// Writes land at the clock edge; reads reflect the current contents with zero latency.
module regfile_4x16
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [1:0]        i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [1:0]        i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [1:0]        i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic [1:0]        i_raddr_h,
  output logic [DATA_W-1:0] o_rdata_h
);
  logic [DATA_W-1:0] r_mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];
  assign o_rdata_h = r_mem[i_raddr_h];
endmodule

// File: rtl/alu_ctrl.sv
// Sequences one external-ALU operation: DRIVE_B -> EXEC -> READ -> DONE, done four cycles after start.
// Starts outside IDLE are dropped; host writes are honoured only in IDLE.
module alu_ctrl
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [1:0]        rd,
  input  logic [1:0]        rs1,
  input  logic [1:0]        rs2,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_a,
  inout  wire  [DATA_W-1:0] data,
  output logic              ialu,
  output logic              ealu,
  output logic              _shl,
  output logic              _add,
  output logic              _sub,
  output logic              _xor,
  output logic              _or,
  output logic              _and,
  output logic              _shr,
  output logic              _not
);
  state_e            r_state;
  op_e               r_op;
  logic [1:0]        r_rd;
  logic [1:0]        r_rs1;
  logic [1:0]        r_rs2;

  logic              w_data_oe;
  logic              w_host_we;
  logic              w_alu_we;
  logic              w_we;
  logic [1:0]        w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata_b;
  logic [7:0]        w_strb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= OP_SHL;
      r_rd    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= DRIVE_B;
            r_op    <= op_e'(op);
            r_rd    <= rd;
            r_rs1   <= rs1;
            r_rs2   <= rs2;
          end
        end
        DRIVE_B: r_state <= EXEC;
        EXEC:    r_state <= READ;
        READ:    r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Bus drive and ealu both come straight off r_state, so they can never overlap.
  assign w_data_oe = (r_state == DRIVE_B) || (r_state == EXEC);
  assign ealu      = (r_state == READ);
  assign ialu      = (r_state == EXEC);
  assign done      = (r_state == DONE);
  assign busy      = (r_state == DRIVE_B) || (r_state == EXEC) || (r_state == READ);
  assign w_strb    = (r_state == EXEC) ? (8'd1 << r_op) : 8'd0;

  assign _shl = w_strb[OP_SHL];
  assign _add = w_strb[OP_ADD];
  assign _sub = w_strb[OP_SUB];
  assign _xor = w_strb[OP_XOR];
  assign _or  = w_strb[OP_OR];
  assign _and = w_strb[OP_AND];
  assign _shr = w_strb[OP_SHR];
  assign _not = w_strb[OP_NOT];

  assign data = w_data_oe ? w_rdata_b : 'z;

  // Host and ALU writeback never compete: one is IDLE-only, the other READ-only.
  assign w_host_we = wr_en && (r_state == IDLE);
  assign w_alu_we  = (r_state == READ);
  assign w_we      = w_host_we || w_alu_we;
  assign w_waddr   = w_alu_we ? r_rd : wr_addr;
  assign w_wdata   = w_alu_we ? data : wr_data;

  regfile_4x16 u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (r_rs1),
    .o_rdata_a (data_a),
    .i_raddr_b (r_rs2),
    .o_rdata_b (w_rdata_b),
    .i_raddr_h (rd_addr),
    .o_rdata_h (rd_data)
  );
endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboarded bench for alu_ctrl with a behavioural external ALU on the shared data bus.
module tb_alu_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [1:0]  rd, rs1, rs2;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  rd_addr;
  wire  [15:0] rd_data;
  wire         busy, done, ialu, ealu;
  wire  [15:0] data_a;
  wire  [15:0] data;
  wire  [7:0]  strobes;

  typedef struct {
    logic [1:0]  rd;
    logic [15:0] val;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] sh[4];
  int          n_cmp = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          bus_viol = 0;
  int          strb_viol = 0;

  logic [15:0] alu_a, alu_b, alu_y;
  logic [7:0]  alu_s;

  always #5 clk = ~clk;

  alu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rd(rd), .rs1(rs1), .rs2(rs2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .data_a(data_a), .data(data),
    .ialu(ialu), .ealu(ealu),
    ._shl(strobes[0]), ._add(strobes[1]), ._sub(strobes[2]), ._xor(strobes[3]),
    ._or(strobes[4]), ._and(strobes[5]), ._shr(strobes[6]), ._not(strobes[7])
  );

  function automatic logic [15:0] model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    case (o)
      3'd0:    return a << b;
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a ^ b;
      3'd4:    return a | b;
      3'd5:    return a & b;
      3'd6:    return a >> b;
      default: return ~a;
    endcase
  endfunction

  // External ALU: latch operands and strobes mid-EXEC, drive the result while ealu is high.
  always @(negedge clk) begin
    if (ialu) begin
      alu_a <= data_a;
      alu_b <= data;
      alu_s <= strobes;
    end
  end

  always_comb begin
    alu_y = 16'h0;
    for (int k = 0; k < 8; k++)
      if (alu_s[k]) alu_y = model(3'(k), alu_a, alu_b);
  end

  assign data = ealu ? alu_y : 'z;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rst_n && dut.w_data_oe && ealu) bus_viol++;
    if ($countones(strobes) > 1) strb_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rdreg(input logic [1:0] a, output logic [15:0] v);
    rd_addr = a;
    #1;
    v = rd_data;
  endtask

  task automatic chk_regs(input string tag);
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      rdreg(2'(i), v);
      chk(tag, {16'h0, v}, {16'h0, sh[i]});
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    sh[a] = d;
  endtask

  // mode[0]: host write in the start cycle; mode[1]: start held through DRIVE_B..READ;
  // mode[2]: host write attempted during EXEC (must be dropped).
  task automatic do_op(input logic [2:0] o, input logic [1:0] d, input logic [1:0] a,
                       input logic [1:0] b, input logic [2:0] mode,
                       input logic [1:0] wa, input logic [15:0] wd);
    exp_t        e;
    logic [19:0] sig;
    logic [15:0] da, db;
    int          n, hit, tot;
    if (mode[0]) begin
      wr_en = 1'b1; wr_addr = wa; wr_data = wd; sh[wa] = wd;
    end
    e.rd  = d;
    e.val = model(o, sh[a], sh[b]);
    sbq.push_back(e);
    start = 1'b1; op = o; rd = d; rs1 = a; rs2 = b;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    n = 1; sig = '0; hit = 0; tot = 0; da = '0; db = '0;
    forever begin
      sig = {sig[14:0], busy, ialu, ealu, done, dut.w_data_oe};
      tot += $countones(strobes);
      if (strobes[o]) hit++;
      if (n == 1) begin da = data_a; db = data; end
      if (done || n >= 10) break;
      start   = mode[1] && (n <= 3);
      wr_en   = mode[2] && (n == 2);
      wr_addr = wa; wr_data = wd;
      @(negedge clk);
      n++;
    end
    start = 1'b0; wr_en = 1'b0;
    chk("done_seen", {31'h0, done}, 32'h1);
    chk("latency", n, 4);
    chk("state_seq", {12'h0, sig}, {12'h0, 20'b10001_11001_10100_00010});
    chk("strobe_sel", hit, 1);
    chk("strobe_cnt", tot, 1);
    chk("opnd_a", {16'h0, da}, {16'h0, sh[a]});
    chk("opnd_b", {16'h0, db}, {16'h0, sh[b]});
    rd_addr = d;
    #1;
    e = sbq.pop_front();
    chk("result", {16'h0, rd_data}, {16'h0, e.val});
    sh[e.rd] = e.val;
    @(negedge clk);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    int          d0;
    rst_n = 1'b0; start = 1'b0; op = '0; rd = '0; rs1 = '0; rs2 = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    for (int i = 0; i < 4; i++) sh[i] = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_alu_en", {30'h0, ialu, ealu}, 32'h0);
    chk("rst_strobes", {24'h0, strobes}, 32'h0);
    chk("rst_data_a", {16'h0, data_a}, 32'h0);
    chk("rst_oe", {31'h0, dut.w_data_oe}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_regs("rst_regs");

    // add 5+3 into r2
    wr(2'd0, 16'd5); wr(2'd1, 16'd3);
    do_op(OP_ADD, 2'd2, 2'd0, 2'd1, 3'd0, 2'd0, 16'h0);
    rdreg(2'd2, v);
    chk("add_r2", {16'h0, v}, 32'h0008);

    // 3-5 wraps to 0xFFFE
    wr(2'd0, 16'd3); wr(2'd1, 16'd5);
    do_op(OP_SUB, 2'd3, 2'd0, 2'd1, 3'd0, 2'd0, 16'h0);
    rdreg(2'd3, v);
    chk("sub_r3", {16'h0, v}, 32'h0000FFFE);

    // shift by 16 clears; then NOT of zero
    wr(2'd0, 16'd1); wr(2'd1, 16'd16);
    do_op(OP_SHL, 2'd0, 2'd0, 2'd1, 3'd0, 2'd0, 16'h0);
    rdreg(2'd0, v);
    chk("shl_r0", {16'h0, v}, 32'h0);
    do_op(OP_NOT, 2'd3, 2'd0, 2'd1, 3'd0, 2'd0, 16'h0);
    rdreg(2'd3, v);
    chk("not_r3", {16'h0, v}, 32'h0000FFFF);

    // same-cycle host write feeds the operation; rd aliases rs1
    do_op(OP_XOR, 2'd1, 2'd1, 2'd2, 3'b001, 2'd1, 16'hA5A5);

    // starts during the op and a host write in EXEC must both be dropped
    d0 = done_cnt;
    do_op(OP_OR, 2'd2, 2'd0, 2'd3, 3'b110, 2'd0, 16'h1234);
    repeat (6) @(negedge clk);
    chk("busy_one_done", done_cnt - d0, 1);
    chk_regs("busy_regs");

    // reset in EXEC aborts with no writeback
    wr(2'd0, 16'd7); wr(2'd1, 16'd9);
    start = 1'b1; op = OP_ADD; rd = 2'd2; rs1 = 2'd0; rs2 = 2'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    d0 = done_cnt;
    chk("exec_ialu", {31'h0, ialu}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_oe", {31'h0, dut.w_data_oe}, 32'h0);
    chk("arst_strobes", {24'h0, strobes}, 32'h0);
    chk("arst_alu_en", {30'h0, ialu, ealu}, 32'h0);
    chk("arst_busy_done", {30'h0, busy, done}, 32'h0);
    chk("arst_data_a", {16'h0, data_a}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) sh[i] = 16'h0;
    repeat (6) @(negedge clk);
    chk("arst_no_done", done_cnt - d0, 0);
    chk_regs("arst_regs");

    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(3) == 0) wr(2'($urandom_range(3)), 16'($urandom));
      do_op(3'($urandom_range(7)), 2'($urandom_range(3)), 2'($urandom_range(3)),
            2'($urandom_range(3)), 3'($urandom_range(7)), 2'($urandom_range(3)),
            16'($urandom));
    end
    chk_regs("rand_regs");
    chk("bus_conflict", bus_viol, 0);
    chk("multi_strobe", strb_viol, 0);
    chk("sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
